// File: rtl/mii_pkg.sv
// Shared definitions for the MII hex-dump formatter: ASCII constants, state
// encodings and the nibble-to-ASCII helper.
package mii_pkg;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_HI_ENC   = 2'd1;
    localparam logic [1:0] ST_LO_ENC   = 2'd2;
    localparam logic [1:0] ST_SEP_ENC  = 2'd3;

    localparam logic [1:0] EM_IDLE_ENC      = 2'd0;
    localparam logic [1:0] EM_PULSE_ENC     = 2'd1;
    localparam logic [1:0] EM_WAIT_ACT_ENC  = 2'd2;
    localparam logic [1:0] EM_WAIT_IDLE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_HI   = ST_HI_ENC,
        ST_LO   = ST_LO_ENC,
        ST_SEP  = ST_SEP_ENC
    } fmt_state_t;

    typedef enum logic [1:0] {
        EM_IDLE      = EM_IDLE_ENC,
        EM_PULSE     = EM_PULSE_ENC,
        EM_WAIT_ACT  = EM_WAIT_ACT_ENC,
        EM_WAIT_IDLE = EM_WAIT_IDLE_ENC
    } emit_state_t;

    typedef enum logic [1:0] {
        SEP_SP = 2'd0,
        SEP_CR = 2'd1,
        SEP_LF = 2'd2
    } sep_kind_t;

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_char_emit.sv
// Hands one ASCII character to a UART transmitter: one-cycle tx_dv strobe,
// wait for tx_active to rise (bounded), then wait for it to fall.
module uart_char_emit
    import mii_pkg::*;
#(
    parameter int ACT_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_char,
    input  logic       tx_active,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(ACT_TIMEOUT + 1);

    emit_state_t   state_q, state_d;
    logic          dv_q, dv_d;
    logic [7:0]    byte_q, byte_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EM_IDLE;
            dv_q    <= 1'b0;
            byte_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dv_d    = 1'b0;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            EM_IDLE: begin
                // A busy transmitter holds us here with no strobe.
                if (start && !tx_active) begin
                    state_d = EM_PULSE;
                    dv_d    = 1'b1;
                    byte_d  = tx_char;
                end
            end
            EM_PULSE: begin
                state_d = EM_WAIT_ACT;
                cnt_d   = '0;
            end
            EM_WAIT_ACT: begin
                // Timeout covers a strobe the transmitter never saw.
                if (tx_active || cnt_q == CW'(ACT_TIMEOUT - 1)) state_d = EM_WAIT_IDLE;
                else                                           cnt_d   = cnt_q + CW'(1);
            end
            EM_WAIT_IDLE: begin
                if (!tx_active) begin
                    done    = 1'b1;
                    state_d = EM_IDLE;
                end
            end
            default: state_d = EM_IDLE;
        endcase
    end

    assign tx_dv     = dv_q;
    assign tx_byte   = byte_q;
    assign dbg_state = state_q;

endmodule

// File: rtl/mii_hexdump.sv
// Renders FIFO bytes as "HH " hex text with CR LF at line/frame end and feeds
// the characters one by one to the UART transmitter.
module mii_hexdump
    import mii_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int ACT_TIMEOUT    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_active,
    output logic [1:0] dbg_state,
    output logic [1:0] dbg_emit_state,
    output logic [7:0] dbg_line_cnt
);

    fmt_state_t state_q, state_d;
    sep_kind_t  sep_q, sep_d;
    logic [7:0] byte_r, byte_d;
    logic       last_r, last_d;
    logic [7:0] line_cnt, line_d;
    logic [7:0] line_inc;
    logic       start;
    logic [7:0] ch;
    logic       done;

    assign line_inc = line_cnt + 8'd1;
    assign in_ready = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sep_q    <= SEP_SP;
            byte_r   <= 8'h00;
            last_r   <= 1'b0;
            line_cnt <= 8'h00;
        end else begin
            state_q  <= state_d;
            sep_q    <= sep_d;
            byte_r   <= byte_d;
            last_r   <= last_d;
            line_cnt <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sep_d   = sep_q;
        byte_d  = byte_r;
        last_d  = last_r;
        line_d  = line_cnt;
        start   = 1'b0;
        ch      = CH_SP;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    last_d  = in_last;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                start = 1'b1;
                ch    = hex_ascii(byte_r[7:4]);
                if (done) state_d = ST_LO;
            end
            ST_LO: begin
                start = 1'b1;
                ch    = hex_ascii(byte_r[3:0]);
                if (done) begin
                    // Frame end and full line share one CR LF.
                    if (last_r || line_inc == 8'(BYTES_PER_LINE)) begin
                        sep_d  = SEP_CR;
                        line_d = 8'h00;
                    end else begin
                        sep_d  = SEP_SP;
                        line_d = line_inc;
                    end
                    state_d = ST_SEP;
                end
            end
            ST_SEP: begin
                start = 1'b1;
                case (sep_q)
                    SEP_CR:  ch = CH_CR;
                    SEP_LF:  ch = CH_LF;
                    default: ch = CH_SP;
                endcase
                if (done) begin
                    if (sep_q == SEP_CR) sep_d   = SEP_LF;
                    else                 state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_char_emit #(
        .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_emit (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .tx_char   (ch),
        .tx_active (tx_active),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .done      (done),
        .dbg_state (dbg_emit_state)
    );

    assign dbg_state    = state_q;
    assign dbg_line_cnt = line_cnt;

endmodule

// File: tb/tb_mii_hexdump.sv
// Directed bench for mii_hexdump: UART model, character monitor and
// per-scenario checks against hand-computed character streams.
module tb_mii_hexdump;

    localparam int BPL    = 16;
    localparam int ACT_TO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic [1:0] dbg_state;
    logic [1:0] dbg_emit_state;
    logic [7:0] dbg_line_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mii_hexdump #(
        .BYTES_PER_LINE(BPL),
        .ACT_TIMEOUT(ACT_TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .tx_dv          (tx_dv),
        .tx_byte        (tx_byte),
        .tx_active      (tx_active),
        .dbg_state      (dbg_state),
        .dbg_emit_state (dbg_emit_state),
        .dbg_line_cnt   (dbg_line_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- UART model ----------------
    int   busy_cnt = 0;
    logic never_mode = 1'b0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_dv && !never_mode) busy_cnt <= 10;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
    end
    assign tx_active = (busy_cnt != 0) || force_busy;

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    logic       prev_dv = 1'b0;
    int         dv_double = 0;
    int         tb_line = 0;

    always @(negedge clk) begin
        if (tx_dv) begin
            got_q.push_back(tx_byte);
            got_cyc.push_back(cyc);
            if (prev_dv) dv_double++;
        end
        prev_dv = tx_dv;
    end

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic exp_byte(input logic [7:0] b, input logic last);
        exp_q.push_back(hx(b[7:4]));
        exp_q.push_back(hx(b[3:0]));
        tb_line++;
        if (last || tb_line == BPL) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            tb_line = 0;
        end else begin
            exp_q.push_back(8'h20);
        end
    endtask

    // ---------------- driver tasks ----------------
    int acc_cyc;
    int n;

    task automatic clear_sb();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_wait: in_ready=%b, want 1 within 600 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        n = 0;
        @(negedge clk);
        while (!(dbg_state == 2'd0 && dbg_emit_state == 2'd0 && !tx_active) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL wait_done: state=%0d emit=%0d, want idle within 2000 cycles",
                     dbg_state, dbg_emit_state);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1)    begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        vectors++; if (tx_dv !== 1'b0)       begin miscompares++; $display("FAIL rst_tx_dv: got %b want 0", tx_dv); end
        vectors++; if (tx_byte !== 8'h00)    begin miscompares++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
        vectors++; if (dbg_line_cnt !== 8'h00) begin miscompares++; $display("FAIL rst_line_cnt: got %h want 00", dbg_line_cnt); end
        vectors++; if (dbg_state !== 2'd0)   begin miscompares++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_a5();
        logic saw_act3;
        logic [7:0] g;
        clear_sb();
        exp_q = '{8'h41, 8'h35, 8'h20};
        tb_line = 1;
        send_byte(8'hA5, 1'b0);
        saw_act3 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (got_q.size() == 3 && tx_active) saw_act3 = 1'b1;
            n++;
        end while (!in_ready && n < 500);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL a5_ready_back: got %b want 1", in_ready); end
        vectors++; if (saw_act3 !== 1'b1 || got_q.size() != 3 || tx_active !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_ready_timing: chars=%0d saw_active=%b active=%b, want 3/1/0", got_q.size(), saw_act3, tx_active);
        end
        vectors++; if (got_cyc.size() == 0 || got_cyc[0] != acc_cyc + 1) begin
            miscompares++;
            $display("FAIL a5_latency: first dv cycle=%0d want %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, acc_cyc + 1);
        end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL a5_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL a5_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_last();
        logic [7:0] g;
        clear_sb();
        exp_q = '{8'h30, 8'h46, 8'h0D, 8'h0A};
        tb_line = 0;
        send_byte(8'h0F, 1'b1);
        wait_done();
        vectors++; if (dbg_line_cnt !== 8'h00) begin miscompares++; $display("FAIL last_line_cnt: got %h want 00", dbg_line_cnt); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL last_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL last_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_line_wrap();
        logic [7:0] g;
        clear_sb();
        for (int b = 0; b < 16; b++) begin
            exp_byte(8'(b), 1'b0);
            send_byte(8'(b), 1'b0);
        end
        exp_byte(8'h10, 1'b0);
        send_byte(8'h10, 1'b0);
        wait_done();
        vectors++; if (dbg_line_cnt !== 8'h01) begin miscompares++; $display("FAIL wrap_line_cnt: got %h want 01", dbg_line_cnt); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL wrap_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_frame_on_boundary();
        logic [7:0] g;
        int crs;
        clear_sb();
        for (int b = 8'h11; b < 8'h1F; b++) begin
            exp_byte(8'(b), 1'b0);
            send_byte(8'(b), 1'b0);
        end
        exp_byte(8'h1F, 1'b1);
        send_byte(8'h1F, 1'b1);
        wait_done();
        crs = 0;
        foreach (got_q[i]) if (got_q[i] == 8'h0D) crs++;
        vectors++; if (crs != 1) begin miscompares++; $display("FAIL bound_cr_count: got %0d want 1", crs); end
        vectors++; if (dbg_line_cnt !== 8'h00) begin miscompares++; $display("FAIL bound_line_cnt: got %h want 00", dbg_line_cnt); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bound_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL bound_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] g;
        int rel_cyc;
        clear_sb();
        exp_q = '{8'h33, 8'h43, 8'h0D, 8'h0A};
        tb_line = 0;
        force_busy = 1'b1;
        send_byte(8'h3C, 1'b1);
        repeat (50) @(negedge clk);
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL stall_dv: got %0d pulses want 0", got_q.size()); end
        vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL stall_state: got %0d want 1", dbg_state); end
        force_busy = 1'b0;
        rel_cyc = cyc;
        wait_done();
        vectors++; if (got_cyc.size() == 0 || got_cyc[0] != rel_cyc + 1) begin
            miscompares++;
            $display("FAIL stall_release: dv cycle=%0d want %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, rel_cyc + 1);
        end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL stall_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] g;
        int gap;
        clear_sb();
        exp_q = '{8'h37, 8'h45, 8'h20};
        tb_line = 1;
        never_mode = 1'b1;
        send_byte(8'h7E, 1'b0);
        wait_done();
        never_mode = 1'b0;
        for (int i = 1; i < 3; i++) begin
            gap = (i < got_cyc.size()) ? got_cyc[i] - got_cyc[i-1] : -1;
            vectors++; if (gap < ACT_TO + 1 || gap > ACT_TO + 3) begin
                miscompares++;
                $display("FAIL timeout_gap[%0d]: got %0d cycles want %0d..%0d", i, gap, ACT_TO + 1, ACT_TO + 3);
            end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL timeout_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL timeout_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] g;
        clear_sb();
        send_byte(8'h5A, 1'b0);
        n = 0;
        while (!(dbg_state == 2'd2 && tx_dv) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n >= 500) begin miscompares++; $display("FAIL rmid_reach_lo: state=%0d dv=%b want 2/1", dbg_state, tx_dv); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (tx_dv !== 1'b0)     begin miscompares++; $display("FAIL rmid_tx_dv: got %b want 0", tx_dv); end
        vectors++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        vectors++; if (dbg_line_cnt !== 8'h00) begin miscompares++; $display("FAIL rmid_line_cnt: got %h want 00", dbg_line_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        tb_line = 0;
        clear_sb();
        exp_byte(8'hC3, 1'b1);
        send_byte(8'hC3, 1'b1);
        wait_done();
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            vectors++; if (g !== exp_q[i]) begin miscompares++; $display("FAIL rmid_char[%0d]: got %h want %h", i, g, exp_q[i]); end
        end
        vectors++; if (dv_double != 0) begin miscompares++; $display("FAIL dv_back_to_back: got %0d double pulses want 0", dv_double); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_a5();
        test_last();
        test_line_wrap();
        test_frame_on_boundary();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded 2 ms, want completion");
        $fatal(1, "watchdog");
    end

endmodule
